knn_distance_stage: RTL and testbench

KNN_DISTANCE_STAGE -- requirements
Module: knn_distance_stage

---
 rtl/knn_pkg.sv | 38 +++
 rtl/knn_distance_stage_if.sv | 32 +++
 rtl/knn_diff_term.sv | 33 +++
 rtl/knn_distance_stage.sv | 148 ++++++++++++++
 tb/tb_knn_distance_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: shared types and sizing helpers for the KNN distance stage.
//
// Contents: FSM state enum, default sample width and dimension count, width of the
// point-index output, and width helpers for the per-dimension term and accumulator.
//
// Optional feature: define KNN_MANHATTAN_EN to build an L1 (Manhattan) distance
// instead of the default squared L2 distance.
package knn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoadRef,
        StAccum,
        StFlush
    } knn_state_e;

    localparam int unsigned DefaultDataWidth          = 32;
    localparam int unsigned DefaultNumberOfDimensions = 5;
    localparam int unsigned NameWidth                 = 32;

    // |diff| always fits dw+1 bits; its square fits 2*dw+2 bits.
    function automatic int unsigned term_width(int unsigned dw);
`ifdef KNN_MANHATTAN_EN
        return dw + 1;
`else
        return 2 * dw + 2;
`endif
    endfunction

    function automatic int unsigned acc_width(int unsigned dw);
`ifdef KNN_MANHATTAN_EN
        return dw + 8;
`else
        return 2 * dw + 8;
`endif
    endfunction

endpackage

// File: rtl/knn_distance_stage_if.sv
// knn_distance_stage_if: job control, sample stream and distance result signals.
//
// slave modport  (the stage): start, done, wr_en, dataValueIn in;
//                             distValid, distName, distValue, distDone, busy, partialErr out.
// master modport (the feeder): the reverse directions.
interface knn_distance_stage_if #(
    parameter int unsigned dataWidth = knn_pkg::DefaultDataWidth
) ();
    import knn_pkg::*;

    logic                        start;
    logic                        done;
    logic                        wr_en;
    logic signed [dataWidth-1:0] dataValueIn;
    logic                        distValid;
    logic [NameWidth-1:0]        distName;
    logic [dataWidth-1:0]        distValue;
    logic                        distDone;
    logic                        busy;
    logic                        partialErr;

    modport master (
        output start, done, wr_en, dataValueIn,
        input  distValid, distName, distValue, distDone, busy, partialErr
    );

    modport slave (
        input  start, done, wr_en, dataValueIn,
        output distValid, distName, distValue, distDone, busy, partialErr
    );

endinterface

// File: rtl/knn_diff_term.sv
// knn_diff_term: combinational per-dimension distance term.
//
// Ports: sample_i - incoming signed sample
//        ref_i    - matching signed reference sample
//        term_o   - |sample_i - ref_i| with KNN_MANHATTAN_EN, else its square
module knn_diff_term import knn_pkg::*; #(
    parameter int unsigned dataWidth = DefaultDataWidth
) (
    input  logic signed [dataWidth-1:0]            sample_i,
    input  logic signed [dataWidth-1:0]            ref_i,
    output logic [term_width(dataWidth)-1:0]       term_o
);

    logic signed [dataWidth:0] diff;
    logic [dataWidth:0]        mag;
`ifndef KNN_MANHATTAN_EN
    logic [2*dataWidth+1:0]    mag_ext;
`endif

    always_comb begin
        // One extra bit so the difference of two extreme samples cannot overflow.
        diff = {sample_i[dataWidth-1], sample_i} - {ref_i[dataWidth-1], ref_i};
        mag  = diff[dataWidth] ? $unsigned(-diff) : $unsigned(diff);
`ifdef KNN_MANHATTAN_EN
        term_o = mag;
`else
        // Squaring the magnitude gives the same result as squaring diff, unsigned.
        mag_ext = {{(dataWidth + 1){1'b0}}, mag};
        term_o  = mag_ext * mag_ext;
`endif
    end

endmodule

// File: rtl/knn_distance_stage.sv
// knn_distance_stage: streams a reference vector, then points, and emits the saturated
// distance of each point to the reference.
//
// Ports: clk, reset (async, active-high) and bus (slave modport of knn_distance_stage_if).
//   start rise in idle begins a job; the first numberOfDimensions wr_en beats load the
//   reference, every following group of numberOfDimensions beats is one point.
//   distValid pulses one cycle after a point's last beat with distName/distValue.
//   done ends the job; distDone pulses once; partialErr flags a job cut mid-vector.
//
// Optional feature: KNN_MANHATTAN_EN selects L1 distance (default: squared L2).
module knn_distance_stage import knn_pkg::*; #(
    parameter int unsigned dataWidth          = DefaultDataWidth,
    parameter int unsigned numberOfDimensions = DefaultNumberOfDimensions
) (
    input logic                 clk,
    input logic                 reset,
    knn_distance_stage_if.slave bus
);

    localparam int unsigned AccW  = acc_width(dataWidth);
    localparam int unsigned TermW = term_width(dataWidth);
    localparam int unsigned DimW  = (numberOfDimensions > 1) ? $clog2(numberOfDimensions) : 1;
    localparam logic [DimW-1:0] LastDim = DimW'(numberOfDimensions - 1);

    knn_state_e                  state_q;
    logic [DimW-1:0]             dim_q;
    logic [AccW-1:0]             acc_q;
    logic [NameWidth-1:0]        point_count_q;
    logic signed [dataWidth-1:0] ref_q [numberOfDimensions];
    logic                        start_q;
    logic                        busy_q;
    logic                        partial_err_q;
    logic                        dist_valid_q;
    logic                        dist_done_q;
    logic [NameWidth-1:0]        dist_name_q;
    logic [dataWidth-1:0]        dist_value_q;

    logic [TermW-1:0]            term;
    logic [AccW-1:0]             acc_sum;
    logic [dataWidth-1:0]        dist_sat;
    logic                        start_rise;
    logic                        last_beat;

    knn_diff_term #(
        .dataWidth (dataWidth)
    ) u_diff_term (
        .sample_i (bus.dataValueIn),
        .ref_i    (ref_q[dim_q]),
        .term_o   (term)
    );

    always_comb begin
        start_rise = bus.start & ~start_q;
        last_beat  = bus.wr_en && (dim_q == LastDim);
        acc_sum    = acc_q + AccW'(term);
        dist_sat   = (|acc_sum[AccW-1:dataWidth]) ? '1 : acc_sum[dataWidth-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            dim_q         <= '0;
            acc_q         <= '0;
            point_count_q <= '0;
            for (int unsigned i = 0; i < numberOfDimensions; i++) begin
                ref_q[i] <= '0;
            end
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            partial_err_q <= 1'b0;
            dist_valid_q  <= 1'b0;
            dist_done_q   <= 1'b0;
            dist_name_q   <= '0;
            dist_value_q  <= '0;
        end else begin
            start_q      <= bus.start;
            dist_valid_q <= 1'b0;
            dist_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_rise) begin
                        state_q       <= StLoadRef;
                        busy_q        <= 1'b1;
                        dim_q         <= '0;
                        acc_q         <= '0;
                        point_count_q <= '0;
                        partial_err_q <= 1'b0;
                    end
                end
                StLoadRef: begin
                    if (bus.done) begin
                        partial_err_q <= 1'b1;
                        dist_done_q   <= 1'b1;
                        dim_q         <= '0;
                        state_q       <= StFlush;
                    end else if (bus.wr_en) begin
                        ref_q[dim_q] <= bus.dataValueIn;
                        if (dim_q == LastDim) begin
                            dim_q   <= '0;
                            state_q <= StAccum;
                        end else begin
                            dim_q <= dim_q + DimW'(1);
                        end
                    end
                end
                StAccum: begin
                    if (last_beat) begin
                        dist_valid_q  <= 1'b1;
                        dist_value_q  <= dist_sat;
                        dist_name_q   <= point_count_q;
                        acc_q         <= '0;
                        dim_q         <= '0;
                        point_count_q <= point_count_q + NameWidth'(1);
                    end else if (bus.wr_en) begin
                        acc_q <= acc_sum;
                        dim_q <= dim_q + DimW'(1);
                    end
                    // A point completed on the same beat as done is not partial.
                    if (bus.done) begin
                        if ((dim_q != '0) && !last_beat) begin
                            partial_err_q <= 1'b1;
                        end
                        acc_q       <= '0;
                        dim_q       <= '0;
                        dist_done_q <= 1'b1;
                        state_q     <= StFlush;
                    end
                end
                StFlush: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.distValid  = dist_valid_q;
    assign bus.distName   = dist_name_q;
    assign bus.distValue  = dist_value_q;
    assign bus.distDone   = dist_done_q;
    assign bus.busy       = busy_q;
    assign bus.partialErr = partial_err_q;

endmodule

// File: tb/tb_knn_distance_stage.sv
// tb_knn_distance_stage: directed bench for knn_distance_stage with an arithmetic
// distance model, a per-cycle output compare process and literal result checks.
module tb_knn_distance_stage;

    typedef int vec_t [5];

    typedef struct {
        longint      cyc;
        logic [31:0] name;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    longint cyc = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t        exp_q [$];
    longint      done_q [$];
    logic [31:0] obs_val [$];
    logic [31:0] obs_name [$];

    vec_t        model_ref;
    logic [31:0] model_name;
    int          lit [5];

    knn_distance_stage_if #(.dataWidth(32)) bus ();

    knn_distance_stage #(
        .dataWidth          (32),
        .numberOfDimensions (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string what, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", what, got, exp, cyc);
        end
    endtask

    // Distance straight from the definition: sum of |p-r| or (p-r)^2, clamped to 32 bits.
    function automatic logic [31:0] model_dist(input vec_t r, input vec_t p);
        logic [127:0] s = '0;
        for (int d = 0; d < 5; d++) begin
            longint diff = longint'(p[d]) - longint'(r[d]);
            longint mag  = (diff < 0) ? -diff : diff;
`ifdef KNN_MANHATTAN_EN
            s += 128'(mag);
`else
            s += 128'(mag) * 128'(mag);
`endif
        end
        return (s > 128'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Compare process: distValid/distDone must pulse exactly on the predicted cycles.
    always @(negedge clk) begin
        if (!reset) begin
            logic want_v, want_d;
            want_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            want_d = (done_q.size() > 0) && (done_q[0] == cyc);
            check("distValid", 64'(bus.distValid), 64'(want_v));
            check("distDone", 64'(bus.distDone), 64'(want_d));
            if (want_v) begin
                if (bus.distValid) begin
                    check("distName", 64'(bus.distName), 64'(exp_q[0].name));
                    check("distValue", 64'(bus.distValue), 64'(exp_q[0].val));
                    obs_val.push_back(bus.distValue);
                    obs_name.push_back(bus.distName);
                end
                void'(exp_q.pop_front());
            end
            if (want_d) void'(done_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.wr_en = 1'b0;
            bus.done  = 1'b0;
            bus.start = 1'b0;
        end
    endtask

    task automatic beat(input int v);
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.done        = 1'b0;
        bus.wr_en       = 1'b1;
        bus.dataValueIn = v;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        bus.done  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        model_name = 0;
    endtask

    task automatic load_ref(input vec_t r);
        for (int d = 0; d < 5; d++) beat(r[d]);
        model_ref = r;
    endtask

    task automatic send_point(input vec_t p, input int gap, input bit done_on_last);
        for (int d = 0; d < 5; d++) begin
            if (d > 0 && gap > 0) idle(gap);
            beat(p[d]);
        end
        exp_q.push_back('{cyc: cyc + 1, name: model_name, val: model_dist(model_ref, p)});
        model_name++;
        if (done_on_last) begin
            bus.done = 1'b1;
            done_q.push_back(cyc + 1);
        end
    endtask

    task automatic send_done();
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        bus.done  = 1'b1;
        done_q.push_back(cyc + 1);
        @(posedge clk); #1;
        bus.done = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " distValid"}, 64'(bus.distValid), 64'd0);
        check({tag, " distDone"}, 64'(bus.distDone), 64'd0);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " partialErr"}, 64'(bus.partialErr), 64'd0);
        check({tag, " distName"}, 64'(bus.distName), 64'd0);
        check({tag, " distValue"}, 64'(bus.distValue), 64'd0);
    endtask

    task automatic check_lits(input int base);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("literal value %0d", base + k), 64'(obs_val[base + k]), 64'(lit[k]));
            check($sformatf("literal name %0d", base + k), 64'(obs_name[base + k]), 64'(k));
        end
    endtask

    initial begin
        vec_t r0, pa, pb, pc, pd, rmin, pmax;
        r0   = '{1, -2, 2, -2, 3};
        pa   = '{5, 10, 7, 9, 6};
        pb   = '{1, 1, 1, 1, 1};
        pc   = '{2, 2, 2, 2, 2};
        pd   = '{5, 5, 5, 5, 5};
        rmin = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000};
        pmax = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF};
`ifdef KNN_MANHATTAN_EN
        lit = '{35, 9, 10, 10, 23};
`else
        lit = '{315, 23, 34, 34, 127};
`endif
        model_name      = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.done        = 1'b0;
        bus.wr_en       = 1'b0;
        bus.dataValueIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        idle(1);
        check_outputs_zero("post-reset");

        // Job 1: back-to-back beats.
        pulse_start();
        check("busy after start", 64'(bus.busy), 64'd1);
        load_ref(r0);
        send_point(pa, 0, 0);
        send_point(pb, 0, 0);
        send_point(pc, 0, 0);
        send_point(pc, 0, 0);
        send_point(pd, 0, 0);
        send_done();
        idle(2);
        check("job1 partialErr", 64'(bus.partialErr), 64'd0);
        check("job1 busy", 64'(bus.busy), 64'd0);
        check_lits(0);

        // Job 2: same data with gaps, plus a start rise while busy.
        pulse_start();
        load_ref(r0);
        send_point(pa, 1, 0);
        idle(1);
        @(posedge clk); #1;
        bus.start = 1'b1;
        idle(2);
        send_point(pb, 2, 0);
        send_point(pc, 3, 0);
        send_point(pc, 1, 0);
        send_point(pd, 2, 0);
        idle(3);
        send_done();
        idle(2);
        check("job2 partialErr", 64'(bus.partialErr), 64'd0);
        check("job2 busy", 64'(bus.busy), 64'd0);
        check_lits(5);

        // Partial point: done after two beats.
        pulse_start();
        load_ref(r0);
        beat(5);
        beat(10);
        send_done();
        idle(2);
        check("partial partialErr", 64'(bus.partialErr), 64'd1);
        check("partial busy", 64'(bus.busy), 64'd0);

        // Done while loading the reference; new start must clear partialErr first.
        pulse_start();
        check("restart clears partialErr", 64'(bus.partialErr), 64'd0);
        beat(1);
        beat(2);
        send_done();
        idle(2);
        check("load_ref partialErr", 64'(bus.partialErr), 64'd1);

        // Saturation with extreme samples.
        pulse_start();
        load_ref(rmin);
        send_point(pmax, 0, 0);
        send_done();
        idle(2);
        check("saturated value", 64'(obs_val[10]), 64'h0000_0000_FFFF_FFFF);

        // Reset mid-point, then restart.
        pulse_start();
        load_ref(r0);
        beat(5);
        beat(10);
        beat(7);
        @(posedge clk); #3;
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        check_outputs_zero("mid-job reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        check("no restart without start", 64'(bus.busy), 64'd0);
        pulse_start();
        load_ref(r0);
        send_point(pa, 0, 0);
        // Final beat of a point coincides with done: the point must still be emitted.
        send_point(pb, 0, 1);
        idle(3);
        check("restart name", 64'(obs_name[11]), 64'd0);
        check("restart value", 64'(obs_val[11]), 64'(lit[0]));
        check("done-on-last name", 64'(obs_name[12]), 64'd1);
        check("done-on-last value", 64'(obs_val[12]), 64'(lit[1]));
        check("done-on-last partialErr", 64'(bus.partialErr), 64'd0);
        check("final busy", 64'(bus.busy), 64'd0);
        check("pending results", 64'(exp_q.size()), 64'd0);
        check("pending done pulses", 64'(done_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
